axi_line_refill_rd: RTL and testbench
=====================================

Name: axi_line_refill_rd

Overview:
- Parametrised AXI read master that turns one cache-line refill request into a single AR burst.
- Collects the R beats into a full line, then returns it with a merged response.
- Sits between the cache miss handler and the AXI read channels.
- Generalises the fixed 128-bit / 2-bit-len channel definitions: parametrised data width, line size and 8-bit len, plus an optional WRAP (critical-word-first) mode.

Parameters:
- ADDR_W, 40, AXI address width
- DATA_W, 128, R data width; power of 2, >= 32
- ID_W, 5, AR/R id width
- LINE_BYTES, 64, cache line size; power of 2; BEATS = LINE_BYTES/(DATA_W/8), 1..256
- WRAP_EN, 0, 0 = INCR burst from the line base; 1 = WRAP burst starting at the requested beat

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  refill request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_W  miss address (byte)
- req_id  in  ID_W  transaction id
- ar_valid  out  1  AR valid
- ar_ready  in  1  AR ready
- ar_id  out  ID_W  AR id
- ar_addr  out  ADDR_W  AR address
- ar_len  out  8  BEATS-1
- ar_size  out  3  log2(DATA_W/8)
- ar_burst  out  2  1=INCR, 2=WRAP
- ar_lock  out  1  constant 0
- ar_cache  out  4  constant 4'b0011
- ar_prot  out  3  constant 3'b000
- r_valid  in  1  R valid
- r_ready  out  1  R ready
- r_id  in  ID_W  R id
- r_data  in  DATA_W  R data
- r_resp  in  2  R response
- r_last  in  1  R last
- rsp_valid  out  1  line response valid
- rsp_ready  in  1  line response accepted
- rsp_line  out  LINE_BYTES*8  assembled line; beat k at bits [k*DATA_W +: DATA_W]
- rsp_id  out  ID_W  id of the request
- rsp_resp  out  2  worst R response seen
- rsp_err  out  1  bus error or protocol error

Behaviour:
- Reset values: state IDLE; ar_valid=0, r_ready=0, rsp_valid=0, rsp_err=0, rsp_resp=0, beat counter=0. req_ready=1 (combinational, state==IDLE).
- States: IDLE, ADDR, DATA, DRAIN, RESP. Only one transaction is outstanding at a time.
- IDLE: on req handshake, latch req_id and the AR fields, then go to ADDR.
  - ar_addr = req_addr with the low log2(LINE_BYTES) bits cleared (INCR), or with the low log2(DATA_W/8) bits cleared (WRAP).
  - start_idx = req_addr[log2(LINE_BYTES)-1 : log2(DATA_W/8)] when WRAP_EN=1, else 0.
  - Clear the merged resp and err.
- ADDR: ar_valid=1. All AR fields are held stable until ar_ready. On handshake go to DATA; AR is issued at the earliest one cycle after the request is accepted.
- DATA: r_ready=1.
  - Each R handshake writes r_data into line slot (start_idx+cnt) mod BEATS and increments cnt.
  - Merged resp: DECERR > SLVERR > OKAY/EXOKAY. EXOKAY is reported as OKAY.
  - rsp_err is set for resp SLVERR/DECERR, r_id != latched id, r_last on beat < BEATS-1, or no r_last on beat BEATS-1.
  - A beat with r_last, or the BEATS-th beat, ends DATA. If that beat had r_last, go to RESP; otherwise go to DRAIN.
  - On early r_last, unfilled slots keep their previous contents.
- DRAIN: r_ready=1; discard beats until an r_last handshake, then go to RESP.
- RESP: rsp_valid=1. rsp_line, rsp_id, rsp_resp and rsp_err are stable until rsp_ready. On handshake go to IDLE; the next request can be accepted the cycle after.
- Line register is not cleared between requests.
- BEATS=1 is legal: ar_len=0, WRAP is not used (burst INCR).
- Reset asserted in any state aborts immediately: AR and R are not completed, no response is produced. The interconnect is expected to be reset with the block.

Test Plan:
- Defaults, req_addr=0x00_0000_1234, id=3 -> ar_addr=0x1200, len=3, size=4, burst=INCR; beats D0..D3 OKAY with last on D3 -> rsp_line={D3,D2,D1,D0}, rsp_id=3, resp=0, err=0.
- WRAP_EN=1, req_addr=0x1230 -> ar_addr=0x1230, burst=WRAP; beats A,B,C,D -> slot3=A, slot0=B, slot1=C, slot2=D; err=0.
- SLVERR on beat 1, DECERR on beat 3 -> rsp_resp=3, rsp_err=1, all 4 slots filled.
- r_last on beat 2 -> rsp after 2 beats, err=1. Separately, no last on beat 4 with 2 extra beats -> DRAIN absorbs them, rsp after the last one, err=1.
- ar_ready held low 5 cycles, rsp_ready held low 3 cycles -> AR fields and rsp fields stable throughout, req_ready=0 until the rsp handshake, no duplicate AR.
- rst pulsed mid-DATA after 2 beats -> ar_valid=0, r_ready=0, rsp_valid=0, req_ready=1 immediately; the next request completes normally.

Source files
------------

// File: rtl/axi_line_refill_rd.sv
// axi_line_refill_rd
// Turns one cache-line refill request into a single AXI AR burst, gathers the
// R beats into a full line and returns it with a merged response. Only one
// transaction is in flight at a time.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready/addr/id  refill request from the miss handler
//   ar_*                     AXI read address channel (master side)
//   r_*                      AXI read data channel (master side)
//   rsp_valid/ready          line response handshake
//   rsp_line                 assembled line, beat k at [k*DATA_W +: DATA_W]
//   rsp_id                   id of the request
//   rsp_resp                 worst R response seen (EXOKAY folded into OKAY)
//   rsp_err                  bus error, id mismatch or r_last misplacement
module axi_line_refill_rd #(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 128,
  parameter int ID_W       = 5,
  parameter int LINE_BYTES = 64,
  parameter int WRAP_EN    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [ID_W-1:0]         req_id,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ID_W-1:0]         ar_id,
  output logic [ADDR_W-1:0]       ar_addr,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic                    ar_lock,
  output logic [3:0]              ar_cache,
  output logic [2:0]              ar_prot,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [ID_W-1:0]         r_id,
  input  logic [DATA_W-1:0]       r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [LINE_BYTES*8-1:0] rsp_line,
  output logic [ID_W-1:0]         rsp_id,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_err
);

  localparam int BPB     = DATA_W / 8;
  localparam int SIZE    = $clog2(BPB);
  localparam int LINE_SH = $clog2(LINE_BYTES);
  localparam int BEATS   = LINE_BYTES / BPB;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W   = $clog2(BEATS + 1);
  localparam int LINE_W  = LINE_BYTES * 8;
  // A single-beat line has nothing to wrap around, so it always goes out INCR.
  localparam bit USE_WRAP = (WRAP_EN != 0) && (BEATS > 1);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << SIZE) - ADDR_W'(1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_RESP
  } state_t;

  // Severity order DECERR(3) > SLVERR(2) > OKAY(0); once EXOKAY is mapped to
  // OKAY the numeric order matches the severity order.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
    logic [1:0] r;
    r = (resp == 2'b01) ? 2'b00 : resp;
    return (r > acc) ? r : acc;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           resp_q;
  logic                 err_q;
  logic [ID_W-1:0]      id_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [IDX_W-1:0]     start_q;
  logic [LINE_W-1:0]    line_q;

  logic                 req_hs, ar_hs, r_hs, rsp_hs;
  logic                 last_beat;
  logic                 beat_err;
  logic [IDX_W-1:0]     slot;

  assign req_hs    = req_valid & req_ready;
  assign ar_hs     = ar_valid & ar_ready;
  assign r_hs      = r_valid & r_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  // r_last must coincide exactly with the final beat; either mismatch is an error.
  assign beat_err  = r_resp[1] | (r_id != id_q) | (r_last != last_beat);
  // Slot index wraps naturally in IDX_W bits because BEATS is a power of two.
  assign slot      = start_q + IDX_W'(cnt_q);

  // Stage: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage: next state and channel handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_hs) state_d = S_ADDR;
      end
      S_ADDR: begin
        ar_valid = 1'b1;
        if (ar_hs) state_d = S_DATA;
      end
      S_DATA: begin
        r_ready = 1'b1;
        if (r_hs) begin
          if (r_last)         state_d = S_RESP;
          else if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        r_ready = 1'b1;
        if (r_hs && r_last) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage: beat counter and merged response status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      resp_q <= 2'b00;
      err_q  <= 1'b0;
    end else if (req_hs) begin
      cnt_q  <= '0;
      resp_q <= 2'b00;
      err_q  <= 1'b0;
    end else if (state_q == S_DATA && r_hs) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      resp_q <= merge_resp(resp_q, r_resp);
      err_q  <= err_q | beat_err;
    end
  end

  // Stage: request capture and line assembly (data path, not reset)
  always_ff @(posedge clk) begin
    if (req_hs) begin
      id_q    <= req_id;
      addr_q  <= USE_WRAP ? (req_addr & BEAT_MASK) : (req_addr & LINE_MASK);
      start_q <= USE_WRAP ? IDX_W'(req_addr >> SIZE) : '0;
    end
    if (state_q == S_DATA && r_hs) begin
      line_q[slot*DATA_W +: DATA_W] <= r_data;
    end
  end

  assign ar_id    = id_q;
  assign ar_addr  = addr_q;
  assign ar_len   = 8'(BEATS - 1);
  assign ar_size  = 3'(SIZE);
  assign ar_burst = USE_WRAP ? 2'b10 : 2'b01;
  assign ar_lock  = 1'b0;
  assign ar_cache = 4'b0011;
  assign ar_prot  = 3'b000;

  assign rsp_line = line_q;
  assign rsp_id   = id_q;
  assign rsp_resp = resp_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_axi_line_refill_rd.sv
module tb_axi_line_refill_rd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared inputs; each instance has its own req_valid.
  logic [1:0]   req_valid_v;
  logic [39:0]  req_addr;
  logic [4:0]   req_id;
  logic         ar_ready, r_valid, r_last, rsp_ready;
  logic [4:0]   r_id;
  logic [127:0] r_data;
  logic [1:0]   r_resp;

  // Instance a: INCR (default). Instance w: WRAP_EN=1.
  logic a_req_ready, a_ar_valid, a_ar_lock, a_r_ready, a_rsp_valid, a_rsp_err;
  logic [4:0] a_ar_id, a_rsp_id;
  logic [39:0] a_ar_addr;
  logic [7:0] a_ar_len;
  logic [2:0] a_ar_size, a_ar_prot;
  logic [1:0] a_ar_burst, a_rsp_resp;
  logic [3:0] a_ar_cache;
  logic [511:0] a_rsp_line;
  logic w_req_ready, w_ar_valid, w_ar_lock, w_r_ready, w_rsp_valid, w_rsp_err;
  logic [4:0] w_ar_id, w_rsp_id;
  logic [39:0] w_ar_addr;
  logic [7:0] w_ar_len;
  logic [2:0] w_ar_size, w_ar_prot;
  logic [1:0] w_ar_burst, w_rsp_resp;
  logic [3:0] w_ar_cache;
  logic [511:0] w_rsp_line;

  axi_line_refill_rd dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[0]), .req_ready(a_req_ready), .req_addr(req_addr), .req_id(req_id),
    .ar_valid(a_ar_valid), .ar_ready(ar_ready), .ar_id(a_ar_id), .ar_addr(a_ar_addr),
    .ar_len(a_ar_len), .ar_size(a_ar_size), .ar_burst(a_ar_burst), .ar_lock(a_ar_lock),
    .ar_cache(a_ar_cache), .ar_prot(a_ar_prot),
    .r_valid(r_valid), .r_ready(a_r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_line(a_rsp_line), .rsp_id(a_rsp_id),
    .rsp_resp(a_rsp_resp), .rsp_err(a_rsp_err)
  );

  axi_line_refill_rd #(.WRAP_EN(1)) dut_w (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[1]), .req_ready(w_req_ready), .req_addr(req_addr), .req_id(req_id),
    .ar_valid(w_ar_valid), .ar_ready(ar_ready), .ar_id(w_ar_id), .ar_addr(w_ar_addr),
    .ar_len(w_ar_len), .ar_size(w_ar_size), .ar_burst(w_ar_burst), .ar_lock(w_ar_lock),
    .ar_cache(w_ar_cache), .ar_prot(w_ar_prot),
    .r_valid(r_valid), .r_ready(w_r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_line(w_rsp_line), .rsp_id(w_rsp_id),
    .rsp_resp(w_rsp_resp), .rsp_err(w_rsp_err)
  );

  // Selected-instance view of the outputs.
  logic sel = 1'b0;
  wire         o_req_ready = sel ? w_req_ready : a_req_ready;
  wire         o_ar_valid  = sel ? w_ar_valid  : a_ar_valid;
  wire         o_r_ready   = sel ? w_r_ready   : a_r_ready;
  wire         o_rsp_valid = sel ? w_rsp_valid : a_rsp_valid;
  wire         o_rsp_err   = sel ? w_rsp_err   : a_rsp_err;
  wire [1:0]   o_rsp_resp  = sel ? w_rsp_resp  : a_rsp_resp;
  wire [4:0]   o_rsp_id    = sel ? w_rsp_id    : a_rsp_id;
  wire [511:0] o_rsp_line  = sel ? w_rsp_line  : a_rsp_line;
  wire [65:0]  o_ar_fields = sel ?
    {w_ar_id, w_ar_addr, w_ar_len, w_ar_size, w_ar_burst, w_ar_lock, w_ar_cache, w_ar_prot} :
    {a_ar_id, a_ar_addr, a_ar_len, a_ar_size, a_ar_burst, a_ar_lock, a_ar_cache, a_ar_prot};

  int total = 0;
  int bad = 0;
  int ar_cnt = 0;

  always @(posedge clk) if (o_ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] t);
    return {16{t}};
  endfunction

  task automatic req(input logic [39:0] a, input logic [4:0] id);
    @(negedge clk);
    chk("req_ready_idle", o_req_ready, 1'b1);
    req_addr = a;
    req_id = id;
    req_valid_v[sel] = 1'b1;
    @(posedge clk);
    #1 req_valid_v = 2'b00;
  endtask

  task automatic take_ar(input logic [4:0] eid, input logic [39:0] ea,
                         input logic [1:0] eburst, input int stall);
    logic [65:0] ef;
    ef = {eid, ea, 8'd3, 3'd4, eburst, 1'b0, 4'b0011, 3'b000};
    @(negedge clk);
    chk("ar_valid", o_ar_valid, 1'b1);
    chk("ar_fields", o_ar_fields, ef);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("ar_hold", {o_ar_valid, o_req_ready, o_ar_fields}, {1'b1, 1'b0, ef});
    end
    ar_ready = 1'b1;
    @(posedge clk);
    #1 ar_ready = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [1:0] rs, input logic lst,
                      input logic [4:0] id);
    int n;
    @(negedge clk);
    r_valid = 1'b1; r_data = d; r_resp = rs; r_last = lst; r_id = id;
    n = 0;
    while (!o_r_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_ready", o_r_ready, 1'b1);
    @(posedge clk);
    #1 r_valid = 1'b0; r_last = 1'b0;
  endtask

  task automatic get_rsp(input logic [511:0] eline, input logic [4:0] eid,
                         input logic [1:0] eresp, input logic eerr, input int stall);
    int n;
    @(negedge clk);
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", o_rsp_valid, 1'b1);
    chk("rsp_line", o_rsp_line, eline);
    chk("rsp_meta", {o_rsp_id, o_rsp_resp, o_rsp_err}, {eid, eresp, eerr});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", {o_rsp_valid, o_req_ready, o_rsp_id, o_rsp_resp, o_rsp_err},
          {1'b1, 1'b0, eid, eresp, eerr});
      chk("rsp_line_hold", o_rsp_line, eline);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", {o_rsp_valid, o_req_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0;
    rst = 1'b1;
    req_valid_v = 2'b00; req_addr = '0; req_id = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; rsp_ready = 1'b0;
    r_id = '0; r_data = '0; r_resp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {o_ar_valid, o_r_ready, o_rsp_valid, o_rsp_err, o_rsp_resp, o_req_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});

    // Basic INCR refill
    req(40'h00_0000_1234, 5'd3);
    take_ar(5'd3, 40'h1200, 2'b01, 0);
    beat(pat(8'hd0), 2'b00, 1'b0, 5'd3);
    beat(pat(8'hd1), 2'b00, 1'b0, 5'd3);
    beat(pat(8'hd2), 2'b00, 1'b0, 5'd3);
    beat(pat(8'hd3), 2'b00, 1'b1, 5'd3);
    get_rsp({pat(8'hd3), pat(8'hd2), pat(8'hd1), pat(8'hd0)}, 5'd3, 2'b00, 1'b0, 0);

    // Error responses: SLVERR on beat 1, DECERR on beat 3
    req(40'h00_0000_2000, 5'd7);
    take_ar(5'd7, 40'h2000, 2'b01, 0);
    beat(pat(8'he0), 2'b00, 1'b0, 5'd7);
    beat(pat(8'he1), 2'b10, 1'b0, 5'd7);
    beat(pat(8'he2), 2'b00, 1'b0, 5'd7);
    beat(pat(8'he3), 2'b11, 1'b1, 5'd7);
    get_rsp({pat(8'he3), pat(8'he2), pat(8'he1), pat(8'he0)}, 5'd7, 2'b11, 1'b1, 0);

    // Early r_last on beat 2: slots 2,3 keep the previous line
    req(40'h00_0000_3040, 5'd9);
    take_ar(5'd9, 40'h3040, 2'b01, 0);
    beat(pat(8'hf0), 2'b00, 1'b0, 5'd9);
    beat(pat(8'hf1), 2'b00, 1'b1, 5'd9);
    get_rsp({pat(8'he3), pat(8'he2), pat(8'hf1), pat(8'hf0)}, 5'd9, 2'b00, 1'b1, 0);

    // Missing r_last: two extra beats drained
    req(40'h00_0000_4000, 5'd1);
    take_ar(5'd1, 40'h4000, 2'b01, 0);
    beat(pat(8'h10), 2'b00, 1'b0, 5'd1);
    beat(pat(8'h11), 2'b00, 1'b0, 5'd1);
    beat(pat(8'h12), 2'b00, 1'b0, 5'd1);
    beat(pat(8'h13), 2'b00, 1'b0, 5'd1);
    @(negedge clk);
    chk("drain_no_rsp0", o_rsp_valid, 1'b0);
    beat(pat(8'h77), 2'b00, 1'b0, 5'd1);
    @(negedge clk);
    chk("drain_no_rsp1", o_rsp_valid, 1'b0);
    beat(pat(8'h88), 2'b00, 1'b1, 5'd1);
    get_rsp({pat(8'h13), pat(8'h12), pat(8'h11), pat(8'h10)}, 5'd1, 2'b00, 1'b1, 0);

    // Backpressure on AR and response
    ar0 = ar_cnt;
    req(40'h00_0000_50ff, 5'd12);
    take_ar(5'd12, 40'h50c0, 2'b01, 5);
    beat(pat(8'h20), 2'b00, 1'b0, 5'd12);
    beat(pat(8'h21), 2'b00, 1'b0, 5'd12);
    beat(pat(8'h22), 2'b00, 1'b0, 5'd12);
    beat(pat(8'h23), 2'b00, 1'b1, 5'd12);
    get_rsp({pat(8'h23), pat(8'h22), pat(8'h21), pat(8'h20)}, 5'd12, 2'b00, 1'b0, 3);
    chk("single_ar", ar_cnt - ar0, 1);

    // WRAP instance, critical word first (EXOKAY folds to OKAY)
    sel = 1'b1;
    req(40'h00_0000_1230, 5'd5);
    take_ar(5'd5, 40'h1230, 2'b10, 0);
    beat(pat(8'haa), 2'b00, 1'b0, 5'd5);
    beat(pat(8'hbb), 2'b01, 1'b0, 5'd5);
    beat(pat(8'hcc), 2'b00, 1'b0, 5'd5);
    beat(pat(8'hdd), 2'b00, 1'b1, 5'd5);
    get_rsp({pat(8'haa), pat(8'hdd), pat(8'hcc), pat(8'hbb)}, 5'd5, 2'b00, 1'b0, 0);
    sel = 1'b0;

    // Reset mid-DATA, then a clean transaction
    req(40'h00_0000_6000, 5'd2);
    take_ar(5'd2, 40'h6000, 2'b01, 0);
    beat(pat(8'h30), 2'b00, 1'b0, 5'd2);
    beat(pat(8'h31), 2'b00, 1'b0, 5'd2);
    rst = 1'b1;
    #1;
    chk("abort_state", {o_ar_valid, o_r_ready, o_rsp_valid, o_req_ready}, 4'b0001);
    @(negedge clk) rst = 1'b0;
    req(40'h00_0000_7010, 5'd4);
    take_ar(5'd4, 40'h7000, 2'b01, 0);
    beat(pat(8'h40), 2'b00, 1'b0, 5'd4);
    beat(pat(8'h41), 2'b00, 1'b0, 5'd4);
    beat(pat(8'h42), 2'b00, 1'b0, 5'd4);
    beat(pat(8'h43), 2'b00, 1'b1, 5'd4);
    get_rsp({pat(8'h43), pat(8'h42), pat(8'h41), pat(8'h40)}, 5'd4, 2'b00, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
